// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a runtime baud divider, optional parity
// and a show-ahead RX FIFO whose entries carry per-frame framing/parity flags.
// Optional feature macro: UART_RX_PARITY_EN (builds the PARITY state and checker).
module uart_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          rx_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rframe_err_o,
  output logic                          rparity_err_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  input  logic                          ovf_clr_i,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);
`ifdef UART_RX_PARITY_EN
  localparam int EW = DATA_W + 2;  // {perr, ferr, data}
`else
  localparam int EW = DATA_W + 1;  // {ferr, data}
`endif

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRKWAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRKWAIT
  } state_t;
`endif

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_prev_reg;
  logic                   rx_s;
  logic                   fall;

  assign rx_s = sync_reg[SYNC_STAGES-1];
  assign fall = rx_prev_reg & ~rx_s;

  // Shift the raw pin through the synchroniser chain; idle level is 1.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx_i};
      rx_prev_reg <= rx_s;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   cnt_reg, cnt_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [BW-1:0]      bit_reg, bit_next;
  logic [DATA_W-1:0]  shift_reg, shift_next;
  logic [DIV_W-1:0]   div_eff;
  logic               cnt_zero;
  logic               push;
  logic [EW-1:0]      push_entry;

  // Divisors below 4 cannot place a mid-bit sample sensibly, so clamp them.
  assign div_eff  = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;
  assign cnt_zero = (cnt_reg == '0);

`ifdef UART_RX_PARITY_EN
  logic par_en_reg, par_en_next;
  logic par_odd_reg, par_odd_next;
  logic perr_reg, perr_next;
  assign push_entry = {perr_reg, ~rx_s, shift_reg};
`else
  logic unused_cfg;
  assign unused_cfg = parity_en_i ^ parity_odd_i;
  assign push_entry = {~rx_s, shift_reg};
`endif

  // Receiver state and per-frame configuration registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      div_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
`ifdef UART_RX_PARITY_EN
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  // Next-state logic: count down to each mid-bit point, then sample rx_s.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    push         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;
    perr_next    = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (fall) begin
          cnt_next     = (div_eff >> 1) - DIV_W'(1);
          div_next     = div_eff;
`ifdef UART_RX_PARITY_EN
          par_en_next  = parity_en_i;
          par_odd_next = parity_odd_i;
          perr_next    = 1'b0;
`endif
          state_next   = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - DIV_W'(1);
        end else if (!rx_s) begin
          cnt_next   = div_reg - DIV_W'(1);
          bit_next   = '0;
          state_next = DATA;
        end else begin
          state_next = IDLE;  // start bit did not hold: glitch
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - DIV_W'(1);
        end else begin
          shift_next = {rx_s, shift_reg[DATA_W-1:1]};
          cnt_next   = div_reg - DIV_W'(1);
          bit_next   = bit_reg + BW'(1);
          if (bit_reg == BW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = par_en_reg ? PARITY : STOP;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - DIV_W'(1);
        end else begin
          perr_next  = rx_s ^ (^shift_reg) ^ par_odd_reg;
          cnt_next   = div_reg - DIV_W'(1);
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_next = cnt_reg - DIV_W'(1);
        end else begin
          push       = 1'b1;
          state_next = rx_s ? IDLE : BRKWAIT;
        end
      end
      BRKWAIT: begin
        // A held-low line must return high before a new start is accepted.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state_reg != IDLE);

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          ovf_reg, ovf_next;
  logic          full, pop, push_ok, ovf_set;
  logic [EW-1:0] head;

  assign full    = (level_reg == LW'(FIFO_DEPTH));
  assign pop     = rvalid_o & rready_i;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // Storage write; no reset needed because reads are gated by rvalid_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= push_entry;
  end

  // Occupancy and sticky overrun; a new overrun beats a clear request.
  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
    ovf_next = ovf_reg;
    if (ovf_set)        ovf_next = 1'b1;
    else if (ovf_clr_i) ovf_next = 1'b0;
  end

  // Pointer, level and overrun registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign head         = mem[rd_ptr_reg];
  assign rvalid_o     = (level_reg != '0);
  assign level_o      = level_reg;
  assign ovf_o        = ovf_reg;
  assign rdata_o      = rvalid_o ? head[DATA_W-1:0] : '0;
  assign rframe_err_o = rvalid_o & head[DATA_W];
`ifdef UART_RX_PARITY_EN
  assign rparity_err_o = rvalid_o & head[DATA_W+1];
`else
  assign rparity_err_o = 1'b0;
`endif

endmodule
